// File: rtl/xnor_resp_checker_pkg.sv
// Shared types for the XNOR response checker: FSM state encoding and the
// {a,b} input-combination index used for coverage and failure capture.
package xnor_chk_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} chk_state_t;

    typedef logic [1:0] combo_t;

    localparam int COMBOS = 4;

    function automatic logic xnor_ref(input logic a, input logic b);
        return ~(a ^ b);
    endfunction

endpackage

// File: rtl/xnor_resp_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_incr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_incr && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/xnor_resp_checker.sv
// Response monitor for a 2-input XNOR gate: accepts (a,b,y) samples, checks
// y against ~(a^b), tracks input coverage and reports a per-run verdict.
module xnor_resp_checker
    import xnor_chk_pkg::*;
#(
    parameter int NUM_SAMPLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             smp_valid,
    output logic             smp_ready,
    input  logic             smp_a,
    input  logic             smp_b,
    input  logic             smp_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic             fail_vld,
    output logic [1:0]       fail_idx
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);

    chk_state_t          r_state;
    logic [CNT_W-1:0]    r_smp_cnt;
    logic [COMBOS-1:0]   r_cov;
    logic                r_done;
    logic                r_fail_vld;
    combo_t              r_fail_idx;

    logic                w_accept;
    logic                w_mismatch;
    logic                w_run_start;
    combo_t              w_combo;
    logic [CNT_W-1:0]    w_err;

    // Ready depends only on registered state, never on smp_valid.
    assign smp_ready   = (r_state == COLLECT);
    assign w_accept    = smp_valid && smp_ready;
    assign w_combo     = {smp_a, smp_b};
    assign w_mismatch  = w_accept && (smp_y != xnor_ref(smp_a, smp_b));
    assign w_run_start = start && (r_state != COLLECT);

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_run_start),
        .i_incr (w_mismatch),
        .o_cnt  (w_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_smp_cnt  <= '0;
            r_cov      <= '0;
            r_done     <= 1'b0;
            r_fail_vld <= 1'b0;
            r_fail_idx <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= COLLECT;
                        r_smp_cnt  <= '0;
                        r_cov      <= '0;
                        r_done     <= 1'b0;
                        r_fail_vld <= 1'b0;
                        r_fail_idx <= '0;
                    end
                end
                COLLECT: begin
                    if (w_accept) begin
                        r_cov[w_combo] <= 1'b1;
                        if (w_mismatch && !r_fail_vld) begin
                            r_fail_vld <= 1'b1;
                            r_fail_idx <= w_combo;
                        end
                        if (r_smp_cnt == LAST) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_smp_cnt <= r_smp_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = (r_state == COLLECT);
    assign done     = r_done;
    assign pass     = r_done && (w_err == '0) && (r_cov == '1);
    assign err_cnt  = w_err;
    assign cov      = r_cov;
    assign fail_vld = r_fail_vld;
    assign fail_idx = r_fail_idx;

endmodule

// File: tb/tb_xnor_resp_checker.sv
// Directed bench for xnor_resp_checker: a scoreboard of expected verdicts is
// filled when a run is driven and drained when the checker reports done.
module tb_xnor_resp_checker;

    typedef struct packed {
        logic [7:0] err;
        logic [3:0] cov;
        logic       fvld;
        logic [1:0] fidx;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start_s = 1'b0;
    logic       smp_valid = 1'b0, smp_a = 1'b0, smp_b = 1'b0, smp_y = 1'b0;

    logic       smp_ready, busy, done, pass, fail_vld;
    logic [7:0] err_cnt;
    logic [3:0] cov;
    logic [1:0] fail_idx;

    logic       smp_ready_s, busy_s, done_s, pass_s, fail_vld_s;
    logic [1:0] err_cnt_s;
    logic [3:0] cov_s;
    logic [1:0] fail_idx_s;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    xnor_resp_checker #(.NUM_SAMPLES(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
        .smp_ready(smp_ready), .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .cov(cov),
        .fail_vld(fail_vld), .fail_idx(fail_idx)
    );

    xnor_resp_checker #(.NUM_SAMPLES(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .smp_valid(smp_valid),
        .smp_ready(smp_ready_s), .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s), .cov(cov_s),
        .fail_vld(fail_vld_s), .fail_idx(fail_idx_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model of one run; each sample is {a,b,y}, smp[0] first.
    function automatic exp_t model(input logic [3:0][2:0] smp, input int n, input int maxerr);
        exp_t e;
        logic a, b, y;
        e = '0;
        for (int i = 0; i < n; i++) begin
            {a, b, y} = smp[i];
            e.cov[{a, b}] = 1'b1;
            if (y == (a ^ b)) begin
                if (!e.fvld) begin
                    e.fvld = 1'b1;
                    e.fidx = {a, b};
                end
                if (int'(e.err) < maxerr) e.err = e.err + 8'd1;
            end
        end
        e.pass = (e.err == 0) && (e.cov == 4'hF);
        return e;
    endfunction

    task automatic check_verdict(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_done"},     32'(done),     32'd1);
        chk({tag, "_err_cnt"},  32'(err_cnt),  32'(e.err));
        chk({tag, "_cov"},      32'(cov),      32'(e.cov));
        chk({tag, "_fail_vld"}, 32'(fail_vld), 32'(e.fvld));
        chk({tag, "_fail_idx"}, 32'(fail_idx), 32'(e.fidx));
        chk({tag, "_pass"},     32'(pass),     32'(e.pass));
    endtask

    task automatic run_main(input string tag, input logic [3:0][2:0] smp, input bit midstart);
        int n;
        sb.push_back(model(smp, 4, 255));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            smp_valid = 1'b1;
            {smp_a, smp_b, smp_y} = smp[i];
            start = midstart && (i == 2);
            @(negedge clk);
        end
        start = 1'b0;
        smp_valid = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd0);
        check_verdict(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"},    32'(smp_ready), 32'd0);
        chk({tag, "_busy"},     32'(busy),      32'd0);
        chk({tag, "_done"},     32'(done),      32'd0);
        chk({tag, "_pass"},     32'(pass),      32'd0);
        chk({tag, "_err_cnt"},  32'(err_cnt),   32'd0);
        chk({tag, "_cov"},      32'(cov),       32'd0);
        chk({tag, "_fail_vld"}, 32'(fail_vld),  32'd0);
        chk({tag, "_fail_idx"}, 32'(fail_idx),  32'd0);
    endtask

    initial begin
        logic [3:0][2:0] golden, stuck0, all11, held;
        int n;
        golden = {3'b111, 3'b100, 3'b010, 3'b001};
        stuck0 = {3'b110, 3'b100, 3'b010, 3'b000};
        all11  = {3'b111, 3'b111, 3'b111, 3'b111};
        held   = {3'b000, 3'b000, 3'b000, 3'b000};

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Valid without ready in IDLE: dropped
        smp_valid = 1'b1;
        {smp_a, smp_b, smp_y} = 3'b000;
        repeat (3) @(negedge clk);
        check_all_zero("idle_drop");
        smp_valid = 1'b0;

        // 1 golden sweep, then outputs hold in DONE
        run_main("golden", golden, 1'b0);
        repeat (3) @(negedge clk);
        chk("done_hold_done", 32'(done), 32'd1);
        chk("done_hold_pass", 32'(pass), 32'd1);
        chk("done_hold_ready", 32'(smp_ready), 32'd0);

        // 2 faulty gate, y stuck at 0
        run_main("stuck0", stuck0, 1'b0);

        // 3 incomplete coverage, plus a start pulse mid-run that must be ignored
        run_main("cov11", all11, 1'b1);

        // 4 start with valid held: exactly NUM_SAMPLES accepted
        sb.push_back(model(held, 4, 255));
        @(negedge clk);
        smp_valid = 1'b1;
        {smp_a, smp_b, smp_y} = 3'b000;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            start = (n == 1);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("held_accept_cycles", 32'(n), 32'd4);
        repeat (3) @(negedge clk);
        chk("held_ready_done", 32'(smp_ready), 32'd0);
        check_verdict("held");
        smp_valid = 1'b0;

        // 5 saturation on the narrow instance
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp_valid = 1'b1;
            {smp_a, smp_b, smp_y} = (i == 0) ? 3'b000 : (i == 1) ? 3'b011 : 3'b101;
            @(negedge clk);
        end
        smp_valid = 1'b0;
        chk("sat_done",     32'(done_s),     32'd1);
        chk("sat_err_cnt",  32'(err_cnt_s),  32'd3);
        chk("sat_cov",      32'(cov_s),      32'h7);
        chk("sat_fail_idx", 32'(fail_idx_s), 32'd0);
        chk("sat_pass",     32'(pass_s),     32'd0);
        chk("sat_main_untouched", 32'(err_cnt), 32'd4);

        // 6 async reset mid-COLLECT, between clock edges
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            smp_valid = 1'b1;
            {smp_a, smp_b, smp_y} = 3'b000;
            @(negedge clk);
        end
        smp_valid = 1'b0;
        chk("midrun_err_cnt", 32'(err_cnt), 32'd2);
        chk("midrun_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk) rst = 1'b0;
        run_main("restart", golden, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
